// File: rtl/moore_seq_detector.sv
// Moore serial pattern detector with KMP-style prefix fallback.
// State is the length of the longest suffix of the accepted bit stream that
// equals a prefix of the loaded pattern. A match is State == WIDTH.
//
// Handshake: En is a plain sample strobe with no back-pressure. In is consumed
// on every rising edge where En=1 and Clear=0. Nothing moves when En=0.
module moore_seq_detector #(
  parameter int WIDTH   = 4,
  parameter int OVERLAP = 1,
  parameter int CNT_W   = 8
) (
  input  logic                           clk,
  input  logic                           Reset_n,
  input  logic                           En,
  input  logic                           In,
  input  logic                           Clear,
  input  logic [WIDTH-1:0]               Pattern,
  output logic                           out,
  output logic [$clog2(WIDTH+1)-1:0]     State,
  output logic [CNT_W-1:0]               Match_cnt,
  output logic                           Cnt_sat
);

  localparam int                SW      = $clog2(WIDTH+1);
  localparam logic [SW-1:0]     FULL    = SW'(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;
  localparam logic [WIDTH:0]    ONES_X  = '1;

  // Per-cycle operation, decoded with Clear > illegal-state recovery > En.
  typedef enum logic [1:0] {
    OP_HOLD    = 2'd0,
    OP_CLEAR   = 2'd1,
    OP_STEP    = 2'd2,
    OP_RECOVER = 2'd3
  } op_e;

  logic [SW-1:0]    r_state;
  logic [WIDTH-1:0] r_hist;
  logic [WIDTH-1:0] r_pat;
  logic [CNT_W-1:0] r_cnt;

  op_e              w_op;
  logic [WIDTH:0]   w_cand;
  int               w_limit;
  logic [SW-1:0]    w_match_len;
  logic [SW-1:0]    w_state_nxt;
  logic [WIDTH-1:0] w_hist_nxt;
  logic [WIDTH-1:0] w_pat_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;

  // History with the incoming bit appended; the low WIDTH bits are the window.
  assign w_cand = {r_hist, In};

  // Decode which operation this cycle performs.
  always_comb begin
    w_op = OP_HOLD;
    if (Clear)
      w_op = OP_CLEAR;
    else if (r_state > FULL)
      w_op = OP_RECOVER;
    else if (En)
      w_op = OP_STEP;
  end

  // Longest prefix of r_pat that is a suffix of (history, In). The answer can
  // never exceed state+1, so bits older than the current match are never
  // consulted; from a full match the bound is WIDTH (overlap) or 1 (restart).
  always_comb begin
    w_limit = int'(r_state) + 1;
    if (r_state == FULL)
      w_limit = (OVERLAP != 0) ? WIDTH : 1;
    w_match_len = '0;
    for (int k = 1; k <= WIDTH; k++) begin
      if ((k <= w_limit) &&
          ((w_cand & ~(ONES_X << k)) == {1'b0, (r_pat >> (WIDTH - k))}))
        w_match_len = SW'(k);
    end
  end

  // Next-state logic for state, history, active pattern and match counter.
  always_comb begin
    w_state_nxt = r_state;
    w_hist_nxt  = r_hist;
    w_pat_nxt   = r_pat;
    w_cnt_nxt   = r_cnt;
    case (w_op)
      OP_CLEAR: begin
        w_state_nxt = '0;
        w_hist_nxt  = '0;
        w_pat_nxt   = Pattern;
        w_cnt_nxt   = '0;
      end
      OP_RECOVER: begin
        w_state_nxt = '0;
        w_hist_nxt  = '0;
      end
      OP_STEP: begin
        w_state_nxt = w_match_len;
        if ((OVERLAP == 0) && (r_state == FULL))
          w_hist_nxt = {{(WIDTH-1){1'b0}}, In};
        else
          w_hist_nxt = w_cand[WIDTH-1:0];
        if ((w_match_len == FULL) && (r_cnt != CNT_MAX))
          w_cnt_nxt = r_cnt + 1'b1;
      end
      default: ;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= '0;
      r_hist  <= '0;
      r_pat   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_hist  <= w_hist_nxt;
      r_pat   <= w_pat_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Moore outputs decoded from registers only.
  assign out       = (r_state == FULL);
  assign State     = r_state;
  assign Match_cnt = r_cnt;
  assign Cnt_sat   = (r_cnt == CNT_MAX);

endmodule

// File: tb/tb_moore_seq_detector.sv
// Directed bench for moore_seq_detector: three instances sharing stimulus
// (overlap, non-overlap, and a 2-bit saturating counter variant).
module tb_moore_seq_detector;

  logic       clk;
  logic       Reset_n;
  logic       En;
  logic       In;
  logic       Clear;
  logic [3:0] Pattern;

  logic       out_a, out_b, out_c;
  logic [2:0] st_a, st_b, st_c;
  logic [7:0] cnt_a, cnt_b;
  logic [1:0] cnt_c;
  logic       sat_a, sat_b, sat_c;

  int checks = 0;
  int errors = 0;

  moore_seq_detector #(.WIDTH(4), .OVERLAP(1), .CNT_W(8)) dut_a (
    .clk(clk), .Reset_n(Reset_n), .En(En), .In(In), .Clear(Clear),
    .Pattern(Pattern), .out(out_a), .State(st_a), .Match_cnt(cnt_a),
    .Cnt_sat(sat_a)
  );

  moore_seq_detector #(.WIDTH(4), .OVERLAP(0), .CNT_W(8)) dut_b (
    .clk(clk), .Reset_n(Reset_n), .En(En), .In(In), .Clear(Clear),
    .Pattern(Pattern), .out(out_b), .State(st_b), .Match_cnt(cnt_b),
    .Cnt_sat(sat_b)
  );

  moore_seq_detector #(.WIDTH(4), .OVERLAP(1), .CNT_W(2)) dut_c (
    .clk(clk), .Reset_n(Reset_n), .En(En), .In(In), .Clear(Clear),
    .Pattern(Pattern), .out(out_c), .State(st_c), .Match_cnt(cnt_c),
    .Cnt_sat(sat_c)
  );

  // Clock and run-time guard.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle and sample 1 time unit after the rising edge.
  task automatic step(input logic en, input logic inb);
    En = en;
    In = inb;
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear(input logic [3:0] pat);
    Clear   = 1'b1;
    Pattern = pat;
    step(1'b1, 1'b1);
    Clear   = 1'b0;
  endtask

  logic [6:0] s30;
  int ea [7] = '{1, 2, 3, 4, 2, 3, 4};
  int eb [7] = '{1, 2, 3, 4, 0, 1, 1};
  logic [4:0] s32;
  int e32 [5] = '{1, 1, 2, 3, 4};
  int cexp [8] = '{0, 0, 0, 1, 2, 3, 3, 3};
  int bexp [8] = '{1, 2, 3, 4, 1, 2, 3, 4};

  initial begin
    s30 = 7'b1011011;  // streamed MSB first
    s32 = 5'b11011;
    Reset_n = 1'b0; En = 1'b0; In = 1'b0; Clear = 1'b0; Pattern = 4'b0000;
    #12;
    chk("rst_state_a", st_a, 0);
    chk("rst_out_a", out_a, 0);
    chk("rst_cnt_a", cnt_a, 0);
    chk("rst_sat_c", sat_c, 0);
    Reset_n = 1'b1;

    // Overlapping vs restart detection of 1011.
    do_clear(4'b1011);
    chk("clr_state_a", st_a, 0);
    for (int i = 0; i < 7; i++) begin
      step(1'b1, s30[6-i]);
      chk($sformatf("ov1_state_%0d", i), st_a, ea[i]);
      chk($sformatf("ov0_state_%0d", i), st_b, eb[i]);
      chk($sformatf("ov1_out_%0d", i), out_a, (i == 3 || i == 6) ? 1 : 0);
    end
    chk("ov1_cnt", cnt_a, 2);
    chk("ov0_cnt", cnt_b, 1);
    chk("c_cnt_2", cnt_c, 2);
    chk("c_sat_2", sat_c, 0);

    // Fallback to state 1 on the second leading 1.
    do_clear(4'b1011);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, s32[4-i]);
      chk($sformatf("fb_state_%0d", i), st_a, e32[i]);
    end
    chk("fb_cnt", cnt_a, 1);

    // En low between bits: state and out hold, including state 4.
    do_clear(4'b1011);
    for (int i = 0; i < 7; i++) begin
      step(1'b1, s30[6-i]);
      chk($sformatf("en_state_%0d", i), st_a, ea[i]);
      step(1'b0, 1'($urandom_range(0, 1)));
      chk($sformatf("hold_state_%0d", i), st_a, ea[i]);
      chk($sformatf("hold_out_%0d", i), out_a, (ea[i] == 4) ? 1 : 0);
    end
    chk("en_cnt", cnt_a, 2);

    // Saturating 2-bit counter on 1111; Pattern moves without Clear.
    do_clear(4'b1111);
    Pattern = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1);
      chk($sformatf("sat_state_%0d", i), st_c, (i < 3) ? i + 1 : 4);
      chk($sformatf("sat_cnt_%0d", i), cnt_c, cexp[i]);
      chk($sformatf("sat_flag_%0d", i), sat_c, (i >= 5) ? 1 : 0);
      chk($sformatf("ov0_1111_%0d", i), st_b, bexp[i]);
    end
    do_clear(4'b1111);
    chk("sat_clr_cnt", cnt_c, 0);
    chk("sat_clr_flag", sat_c, 0);
    chk("sat_clr_state", st_c, 0);

    // Clear held over several cycles ignores En/In.
    Clear = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1);
      chk($sformatf("hold_clr_state_%0d", i), st_a, 0);
      chk($sformatf("hold_clr_out_%0d", i), out_a, 0);
    end
    Clear = 1'b0;

    // Asynchronous reset mid-sequence, then all-zero pattern.
    do_clear(4'b1011);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    chk("pre_rst_state", st_a, 3);
    #2 Reset_n = 1'b0;
    #1;
    chk("arst_state_a", st_a, 0);
    chk("arst_out_a", out_a, 0);
    chk("arst_cnt_a", cnt_a, 0);
    chk("arst_state_b", st_b, 0);
    chk("arst_sat_c", sat_c, 0);
    #2 Reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0);
      chk($sformatf("zero_state_%0d", i), st_a, i + 1);
      chk($sformatf("zero_out_%0d", i), out_a, (i == 3) ? 1 : 0);
    end
    chk("zero_cnt", cnt_a, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/moore_seq_detector.md
MOORE_SEQ_DETECTOR -- requirements
Module: moore_seq_detector

Interface
- REQ-001 Parameter WIDTH, default 4: pattern length in bits; legal range 2..16.
- REQ-002 Parameter OVERLAP, default 1: 1 = overlapping matches are detected; 0 = detection restarts after each match.
- REQ-003 Parameter CNT_W, default 8: width of the match counter; legal range 1..32.
- REQ-004 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
- REQ-005 Port Reset_n, input, 1 bit: asynchronous, active-low reset.
- REQ-006 Port En, input, 1 bit: sample strobe; In is consumed only on cycles where En=1.
- REQ-007 Port In, input, 1 bit: serial data bit.
- REQ-008 Port Clear, input, 1 bit: synchronous clear and pattern load.
- REQ-009 Port Pattern, input, WIDTH bits: target sequence; Pattern[WIDTH-1] is the first bit expected.
- REQ-010 Port out, output, 1 bit: Moore match flag.
- REQ-011 Port State, output, $clog2(WIDTH+1) bits: current state, equal to the matched prefix length.
- REQ-012 Port Match_cnt, output, CNT_W bits: number of matches since reset or Clear.
- REQ-013 Port Cnt_sat, output, 1 bit: high when Match_cnt has saturated.

Function
- REQ-014 Internal register pat_q holds the active pattern.
  - pat_q loads Pattern on every cycle with Clear=1.
  - pat_q is not otherwise affected by changes on Pattern.
- REQ-015 State ranges over 0..WIDTH; state k means the last k accepted bits equal pat_q[WIDTH-1 -: k].
- REQ-016 With En=1 and Clear=0, the next state is the largest k <= WIDTH such that the last k bits of (accepted history followed by In) equal the first k bits of pat_q.
  - Matching prefix-suffix overlaps is required (KMP-style fallback), not a reset-to-0 on mismatch.
- REQ-017 A history shift register of at least WIDTH bits holds the accepted bits for the REQ-016 evaluation.
- REQ-018 From state WIDTH with OVERLAP=1, the next state follows REQ-016 over the full history.
- REQ-019 From state WIDTH with OVERLAP=0, history is discarded; next state = 1 if In == pat_q[WIDTH-1], else 0.
- REQ-020 With En=0 and Clear=0, State, history, out and Match_cnt hold.
- REQ-021 out = 1 exactly when State == WIDTH.
  - out is decoded from registered state only, with no combinational path from In or En.
  - out stays high while En=0 holds state WIDTH.
- REQ-022 Match_cnt increments by 1 on each accepted bit whose next state is WIDTH; latency is one clock from the completing bit to both out=1 and the counter update.
- REQ-023 Match_cnt saturates at 2^CNT_W-1 and does not wrap.
  - Cnt_sat = 1 whenever Match_cnt == 2^CNT_W-1.
- REQ-024 Clear=1 has priority over En.
  - Next cycle: State=0, history=0, Match_cnt=0, Cnt_sat=0, out=0, pat_q=Pattern.
  - In is ignored on the Clear cycle.
- REQ-025 Clear held for multiple cycles keeps all outputs at their cleared values.
- REQ-026 Every reachable encoding is defined; any State value above WIDTH returns to 0 on the next clock edge, regardless of En.

Reset
- REQ-027 Reset_n=0 asynchronously forces State=0, history=0, pat_q=0, Match_cnt=0, Cnt_sat=0, out=0, independent of clk.
- REQ-028 Reset release is sampled synchronously; the first state update occurs on the first rising edge of clk with Reset_n=1.
- REQ-029 Reset asserted mid-sequence discards partial matches.
  - After release, the pattern must be reloaded via Clear; until then the pattern is all zeros.

Verification
- REQ-030 WIDTH=4, OVERLAP=1, Clear with Pattern=4'b1011, then stream 1,0,1,1,0,1,1 with En=1 -> State 1,2,3,4,2,3,4; out high after bits 4 and 7; Match_cnt=2.
- REQ-031 Same stream with OVERLAP=0 -> State 1,2,3,4,0,1,1; one out pulse; Match_cnt=1.
- REQ-032 Pattern=4'b1011, stream 1,1,0,1,1 -> State 1,1,2,3,4, showing fallback to state 1 rather than 0; Match_cnt=1.
- REQ-033 En toggled low between every bit of the REQ-030 stream -> identical State sequence on En=1 cycles; State and out hold on En=0 cycles, with out high for the whole hold in state 4.
- REQ-034 CNT_W=2, Pattern=4'b1111, OVERLAP=1, eight 1s -> Match_cnt 1,2,3,3,3; Cnt_sat=1 from the third match; then Clear -> Match_cnt=0, Cnt_sat=0, State=0.
- REQ-035 Reset_n pulsed low between clock edges while in state 3 -> all outputs 0 immediately; after release, stream 0,0,0,0 -> out high after bit 4 (pattern all zeros).
